// File: rtl/oled_pkg.sv
// Shared opcodes, mode encodings and controller state for the SSD1306 addressing front end.
package oled_pkg;

    localparam int unsigned COL_W  = 7;
    localparam int unsigned PAGE_W = 3;
    localparam int unsigned ADDR_W = 10;

    localparam logic [7:0] OP_SET_MODE    = 8'h20;
    localparam logic [7:0] OP_COL_RANGE   = 8'h21;
    localparam logic [7:0] OP_PAGE_RANGE  = 8'h22;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_COM_PINS    = 8'hDA;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;

    typedef enum logic [1:0] {
        MODE_HORIZ = 2'd0,
        MODE_VERT  = 2'd1,
        MODE_PAGE  = 2'd2
    } addr_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        ARG_MODE,
        COL_A,
        COL_B,
        PAGE_A,
        PAGE_B,
        SKIP1
    } state_e;

    // Single-argument commands this block does not act on; their argument is swallowed.
    function automatic logic is_skip_cmd(input logic [7:0] b);
        return b inside {OP_CONTRAST, OP_CHARGE_PUMP, OP_MUX_RATIO, OP_DISP_OFFSET,
                         OP_CLK_DIV, OP_PRECHARGE, OP_COM_PINS, OP_VCOMH};
    endfunction

    function automatic addr_mode_e decode_mode(input logic [1:0] v);
        return (v == 2'd3) ? MODE_PAGE : addr_mode_e'(v);
    endfunction

endpackage

// File: rtl/ssd1306_addr_ctrl_if.sv
// Byte-stream input and framebuffer write bus of the SSD1306 address controller.
interface ssd1306_addr_ctrl_if;
    import oled_pkg::*;

    logic              byte_valid;
    logic              byte_dc;
    logic [7:0]        byte_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_done;
    logic [1:0]        addr_mode;

    modport master (
        output byte_valid, byte_dc, byte_data,
        input  wr_en, wr_addr, wr_data, frame_done, addr_mode
    );

    modport slave (
        input  byte_valid, byte_dc, byte_data,
        output wr_en, wr_addr, wr_data, frame_done, addr_mode
    );

endinterface

// File: rtl/oled_addr_step.sv
// Combinational next-pointer computation for horizontal, vertical and page addressing.
module oled_addr_step import oled_pkg::*; #(
    parameter int unsigned COLS  = 128,
    parameter int unsigned PAGES = 8
) (
    input  addr_mode_e        mode,
    input  logic [COL_W-1:0]  col,
    input  logic [COL_W-1:0]  col_start,
    input  logic [COL_W-1:0]  col_end,
    input  logic [PAGE_W-1:0] page,
    input  logic [PAGE_W-1:0] page_start,
    input  logic [PAGE_W-1:0] page_end,
    output logic [COL_W-1:0]  col_next,
    output logic [PAGE_W-1:0] page_next,
    output logic              wrap
);

    function automatic logic [COL_W-1:0] col_inc(input logic [COL_W-1:0] c);
        return (32'(c) == COLS - 1) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [PAGE_W-1:0] page_inc(input logic [PAGE_W-1:0] p);
        return (32'(p) == PAGES - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        col_next  = col;
        page_next = page;
        wrap      = 1'b0;
        case (mode)
            MODE_HORIZ: begin
                if (col == col_end) begin
                    col_next = col_start;
                    if (page == page_end) begin
                        page_next = page_start;
                        wrap      = 1'b1;
                    end else begin
                        page_next = page_inc(page);
                    end
                end else begin
                    col_next = col_inc(col);
                end
            end
            MODE_VERT: begin
                if (page == page_end) begin
                    page_next = page_start;
                    if (col == col_end) begin
                        col_next = col_start;
                        wrap     = 1'b1;
                    end else begin
                        col_next = col_inc(col);
                    end
                end else begin
                    page_next = page_inc(page);
                end
            end
            // Page mode ignores the column window entirely.
            default: col_next = col_inc(col);
        endcase
    end

endmodule

// File: rtl/ssd1306_addr_ctrl.sv
// SSD1306 command decoder and GDDRAM address generator feeding a local framebuffer.
module ssd1306_addr_ctrl import oled_pkg::*; #(
    parameter int unsigned COLS  = 128,
    parameter int unsigned PAGES = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    ssd1306_addr_ctrl_if.slave bus
);

    state_e            state;
    addr_mode_e        mode;
    logic [COL_W-1:0]  col, col_start, col_end;
    logic [PAGE_W-1:0] page, page_start, page_end;
    logic [COL_W-1:0]  col_nxt;
    logic [PAGE_W-1:0] page_nxt;
    logic              wrap;
    logic [ADDR_W-1:0] cur_addr;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              frame_done_q;

    logic [7:0]        b;

    assign b        = bus.byte_data;
    assign cur_addr = ADDR_W'(page) * ADDR_W'(COLS) + ADDR_W'(col);

    oled_addr_step #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) u_step (
        .mode       (mode),
        .col        (col),
        .col_start  (col_start),
        .col_end    (col_end),
        .page       (page),
        .page_start (page_start),
        .page_end   (page_end),
        .col_next   (col_nxt),
        .page_next  (page_nxt),
        .wrap       (wrap)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mode         <= MODE_PAGE;
            col          <= '0;
            page         <= '0;
            col_start    <= '0;
            col_end      <= COL_W'(COLS - 1);
            page_start   <= '0;
            page_end     <= PAGE_W'(PAGES - 1);
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.byte_valid) begin
                if (bus.byte_dc) begin
                    // Data always wins: any half-received command is dropped, latched args stay.
                    state        <= IDLE;
                    wr_en_q      <= 1'b1;
                    wr_addr_q    <= cur_addr;
                    wr_data_q    <= b;
                    col          <= col_nxt;
                    page         <= page_nxt;
                    frame_done_q <= wrap;
                end else begin
                    case (state)
                        IDLE: begin
                            if (b == OP_SET_MODE) begin
                                state <= ARG_MODE;
                            end else if (b == OP_COL_RANGE) begin
                                state <= COL_A;
                            end else if (b == OP_PAGE_RANGE) begin
                                state <= PAGE_A;
                            end else if (is_skip_cmd(b)) begin
                                state <= SKIP1;
                            end else if (b[7:4] == 4'h0) begin
                                col[3:0] <= b[3:0];
                            end else if (b[7:3] == 5'b0001_0) begin
                                col[6:4] <= b[2:0];
                            end else if (b[7:3] == 5'b1011_0) begin
                                page <= b[2:0];
                            end
                        end
                        ARG_MODE: begin
                            mode  <= decode_mode(b[1:0]);
                            state <= IDLE;
                        end
                        COL_A: begin
                            col_start <= b[6:0];
                            state     <= COL_B;
                        end
                        COL_B: begin
                            col_end <= b[6:0];
                            col     <= col_start;
                            state   <= IDLE;
                        end
                        PAGE_A: begin
                            page_start <= b[2:0];
                            state      <= PAGE_B;
                        end
                        PAGE_B: begin
                            page_end <= b[2:0];
                            page     <= page_start;
                            state    <= IDLE;
                        end
                        SKIP1:   state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.addr_mode  = mode;

endmodule

// File: tb/tb_ssd1306_addr_ctrl.sv
// Scoreboard bench for ssd1306_addr_ctrl: directed command sequences plus randomized byte streams.
module tb_ssd1306_addr_ctrl;

    localparam int COLS  = 128;
    localparam int PAGES = 8;

    logic clock = 1'b0;
    logic reset_n;

    ssd1306_addr_ctrl_if bus();

    ssd1306_addr_ctrl #(
        .COLS  (COLS),
        .PAGES (PAGES)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int stamp;
        int addr;
        int data;
        int fd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model state; m_pend holds the opcode still waiting for arguments (-1: none).
    int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_pend, m_argn;

    logic [7:0] skip_ops [8] = '{8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 2;
        m_col  = 0;
        m_page = 0;
        m_cs   = 0;
        m_ce   = COLS - 1;
        m_ps   = 0;
        m_pe   = PAGES - 1;
        m_pend = -1;
        m_argn = 0;
    endtask

    task automatic model_byte(input logic dc, input int b);
        exp_t e;
        if (dc) begin
            e.stamp = cyc + 1;
            e.addr  = m_page * COLS + m_col;
            e.data  = b;
            e.fd    = 0;
            if (m_mode == 0) begin
                if (m_col == m_ce) begin
                    m_col = m_cs;
                    if (m_page == m_pe) begin
                        m_page = m_ps;
                        e.fd   = 1;
                    end else m_page = (m_page + 1) % PAGES;
                end else m_col = (m_col + 1) % COLS;
            end else if (m_mode == 1) begin
                if (m_page == m_pe) begin
                    m_page = m_ps;
                    if (m_col == m_ce) begin
                        m_col = m_cs;
                        e.fd  = 1;
                    end else m_col = (m_col + 1) % COLS;
                end else m_page = (m_page + 1) % PAGES;
            end else begin
                m_col = (m_col + 1) % COLS;
            end
            exp_q.push_back(e);
            m_pend = -1;
        end else if (m_pend == 'h20) begin
            m_mode = (b % 4 == 3) ? 2 : b % 4;
            m_pend = -1;
        end else if (m_pend == 'h21 || m_pend == 'h22) begin
            if (m_argn == 0) begin
                if (m_pend == 'h21) m_cs = b % 128;
                else m_ps = b % 8;
                m_argn = 1;
            end else begin
                if (m_pend == 'h21) begin
                    m_ce  = b % 128;
                    m_col = m_cs;
                end else begin
                    m_pe   = b % 8;
                    m_page = m_ps;
                end
                m_pend = -1;
            end
        end else if (m_pend >= 0) begin
            m_pend = -1;
        end else if (b inside {'h20, 'h21, 'h22, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) begin
            m_pend = b;
            m_argn = 0;
        end else if (b <= 'h0F) begin
            m_col = (m_col / 16) * 16 + b;
        end else if (b <= 'h17) begin
            m_col = (m_col % 16) + (b - 'h10) * 16;
        end else if (b >= 'hB0 && b <= 'hB7) begin
            m_page = b - 'hB0;
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        @(negedge clock);
        bus.byte_valid = 1'b1;
        bus.byte_dc    = dc;
        bus.byte_data  = b;
        model_byte(dc, int'(b));
    endtask

    // Idle cycles carry random garbage on dc/data to show they are ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.byte_valid = 1'b0;
            bus.byte_dc    = 1'($urandom);
            bus.byte_data  = 8'($urandom);
        end
    endtask

    task automatic drain();
        idle(2);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_mode();
        idle(1);
        check("addr_mode", bus.addr_mode, m_mode);
    endtask

    task automatic reset_checks();
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_addr_mode", bus.addr_mode, 2);
    endtask

    task automatic do_reset();
        drain();
        @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write", bus.wr_addr, bus.wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_latency", cyc, mon_e.stamp);
                    check("wr_addr", bus.wr_addr, mon_e.addr);
                    check("wr_data", bus.wr_data, mon_e.data);
                    check("frame_done", bus.frame_done, mon_e.fd);
                end
            end else begin
                check("idle_frame_done", bus.frame_done, 0);
                if (exp_q.size() != 0 && exp_q[0].stamp < cyc) begin
                    check("missing_write", cyc, exp_q[0].stamp);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #600000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        reset_n        = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_dc    = 1'b0;
        bus.byte_data  = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset_checks();
        reset_n = 1'b1;

        // Full-window horizontal sweep: 0..1023, wrap on the last byte.
        send(0, 8'h20); send(0, 8'h00);
        check_mode();
        for (int i = 0; i < 1024; i++) send(1, 8'($urandom));
        drain();

        // Sub-window 16..31 x pages 2..3.
        send(0, 8'h21); send(0, 8'h10); send(0, 8'h1F);
        send(0, 8'h22); send(0, 8'h02); send(0, 8'h03);
        for (int i = 0; i < 32; i++) send(1, 8'($urandom));
        drain();

        // Vertical mode, full window.
        do_reset();
        send(0, 8'h20); send(0, 8'h01);
        check_mode();
        for (int i = 0; i < 3; i++) send(1, 8'($urandom));
        drain();

        // Page mode: nibble column commands and column wrap.
        do_reset();
        check_mode();
        send(0, 8'hB3); send(0, 8'h05); send(0, 8'h17);
        send(1, 8'h11); send(1, 8'h22);
        send(0, 8'h0F); send(0, 8'h17);
        send(1, 8'h33); send(1, 8'h44);
        drain();

        // Mode argument 3 falls back to page mode.
        send(0, 8'h20); send(0, 8'h03);
        check_mode();

        // Data aborting a column-range command keeps col_start only.
        do_reset();
        send(0, 8'h20); send(0, 8'h00); send(0, 8'hB2);
        send(0, 8'h21); send(0, 8'h40); send(1, 8'hAA);
        send(0, 8'h0F); send(0, 8'h17);
        send(1, 8'h55); send(1, 8'h66);
        drain();

        // Skip command swallows 0x21 as its argument.
        do_reset();
        send(0, 8'h81); send(0, 8'h21); send(0, 8'h22); send(0, 8'h01); send(0, 8'h01);
        send(1, 8'h77);
        drain();

        // Reset mid-command discards the pending opcode.
        send(0, 8'h21);
        do_reset();
        send(0, 8'hB2); send(1, 8'h88);
        drain();

        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                send(1, 8'($urandom));
            end else if (r < 60) begin
                idle($urandom_range(1, 3));
            end else if (r < 65) begin
                send(0, 8'h20); send(0, 8'($urandom_range(0, 3)));
                check_mode();
            end else if (r < 72) begin
                send(0, ($urandom_range(0, 1) != 0) ? 8'h21 : 8'h22);
                send(0, 8'($urandom));
                if ($urandom_range(0, 5) == 0) send(1, 8'($urandom));
                else send(0, 8'($urandom));
            end else if (r < 80) begin
                case ($urandom_range(0, 2))
                    0:       send(0, 8'($urandom_range(0, 15)));
                    1:       send(0, 8'($urandom_range(16, 23)));
                    default: send(0, 8'($urandom_range(176, 183)));
                endcase
            end else if (r < 85) begin
                send(0, skip_ops[$urandom_range(0, 7)]);
                send(0, 8'($urandom));
            end else if (r < 99) begin
                send(0, 8'($urandom));
            end else begin
                do_reset();
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd1306_addr_ctrl.md
SSD1306_ADDR_CTRL -- requirements
Module: ssd1306_addr_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 128, display width in columns.
REQ-002 SHALL have parameter PAGES, default 8, display height in 8-pixel pages.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe per received byte, already synchronous to clock.
REQ-006 SHALL have port byte_dc  input  1  1 = display data, 0 = command/argument.
REQ-007 SHALL have port byte_data  input  8  received byte.
REQ-008 SHALL have port wr_en  output  1  framebuffer write strobe.
REQ-009 SHALL have port wr_addr  output  10  framebuffer byte address, page*COLS+col.
REQ-010 SHALL have port wr_data  output  8  byte to write.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on full-window wrap.
REQ-012 SHALL have port addr_mode  output  2  current mode: 0 horizontal, 1 vertical, 2 page.

Function
REQ-013 SHALL ignore all inputs in any cycle where byte_valid=0.
REQ-014 SHALL use FSM states IDLE, ARG_MODE, COL_A, COL_B, PAGE_A, PAGE_B, SKIP1.
REQ-015 In IDLE, command byte 0x20 SHALL go to ARG_MODE; 0x21 to COL_A; 0x22 to PAGE_A.
REQ-016 In IDLE, each of 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB SHALL go to SKIP1; SKIP1 SHALL discard the next command byte and return to IDLE.
REQ-017 In IDLE, 0x00-0x0F SHALL set col[3:0]; 0x10-0x17 SHALL set col[6:4]; 0xB0-0xB7 SHALL set page to byte[2:0]; all other commands SHALL be ignored with no state change.
REQ-018 ARG_MODE SHALL load mode from byte[1:0]; value 3 SHALL be treated as 2; return to IDLE.
REQ-019 COL_A SHALL load col_start=byte[6:0] and go to COL_B. COL_B SHALL load col_end=byte[6:0], set col=col_start, and return to IDLE.
REQ-020 PAGE_A/PAGE_B SHALL do the same for page_start/page_end using byte[2:0] and set page=page_start.
REQ-021 A data byte (byte_dc=1) arriving in any non-IDLE state SHALL abort the pending command (no partial update beyond arguments already latched), return to IDLE, and be written normally.
REQ-022 A data byte SHALL produce, on the next cycle, wr_en=1, wr_data=byte, and wr_addr from the pointer value before advancing; latency is exactly 1 cycle.
REQ-023 Horizontal mode: if col==col_end, col<=col_start and advance page; else col+1.
REQ-024 Vertical mode: if page==page_end, page<=page_start and advance col; else page+1.
REQ-025 Advancing the secondary pointer SHALL wrap to its start when it equals its end; that event SHALL pulse frame_done in the same cycle as the wr_en of that byte.
REQ-026 Page mode: col SHALL wrap from COLS-1 to 0; page unchanged; frame_done never pulses.
REQ-027 Pointer increments SHALL be modulo COLS or PAGES; start>end SHALL wrap through 0 until reaching end, never hanging.
REQ-028 wr_en and frame_done SHALL be low in every cycle not given by REQ-022/025.

Reset
REQ-029 On reset_n=0: state IDLE, mode 2, col=0, page=0, col_start=0, col_end=COLS-1, page_start=0, page_end=PAGES-1, wr_en=0, wr_addr=0, wr_data=0, frame_done=0.
REQ-030 Reset asserted mid-command SHALL discard any latched argument; first byte after release is decoded in IDLE.

Structure
REQ-031 Command opcodes, mode encodings and FSM state encoding SHALL live in shared package oled_pkg.
REQ-032 Pointer advance/wrap logic SHALL be one sub-module oled_addr_step (combinational: mode, pointers, ranges -> next pointers, wrap flag).

Verification
REQ-033 Reset, then cmd 0x20,0x00, then 1024 data bytes -> addresses 0..1023 in order, single frame_done on byte 1024.
REQ-034 Cmds 0x21,0x10,0x1F,0x22,0x02,0x03 in horizontal mode, 32 data bytes -> addresses 272..287, 400..415; frame_done on byte 32.
REQ-035 Vertical mode, full window, 3 data bytes -> addresses 0,128,256.
REQ-036 Page mode after reset, cmds 0xB3,0x05,0x17, 2 data -> addresses 501,502; at col 127 next byte wraps to col 0 of page 3 (384).
REQ-037 Cmd 0x21,0x40 then data byte 0xAA -> write at pre-command pointer, col_start=0x40, col_end unchanged, state IDLE.
REQ-038 Cmd 0x81 then 0x21 -> 0x21 discarded as contrast argument; next 0x22 decoded as page command.
